dip_win5x5_gen: RTL and testbench
=================================

Name: dip_win5x5_gen

Overview:
Upstream window generator for the 5x5 median filter. It takes a raster pixel stream with valid/ready handshake and stores the four previous image lines in line buffers. For every fully populated 5x5 neighbourhood it emits all 25 pixels in parallel to the sorter network.
- Windows are produced in valid-region mode only; no border padding.
- The block contains a stream handshake, column/row counters, line-buffer memory and a one-deep output register.

Parameters:
- DAT_WDTH, 8: pixel width in bits.
- IMG_WDTH, 640: pixels per image line, 5..4096; sets line-buffer depth.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_vld  in  1  input pixel valid.
- i_rdy  out  1  block can accept a pixel.
- i_sof  in  1  start of frame; qualified by i_vld && i_rdy.
- i_pix  in  DAT_WDTH  input pixel, raster order.
- o_vld  out  1  window valid.
- o_rdy  in  1  downstream accepts window.
- o_win  out  25*DAT_WDTH  window; element (r,c) at bits [(r*5+c)*DAT_WDTH +: DAT_WDTH].
  - r=0 is the oldest (top) row; c=0 is the oldest (left) column.

Behaviour:
- Reset: o_vld=0, o_win=0, col_cnt=0, row_cnt=0, window registers=0. Line-buffer contents are don't-care.
- Accept: acc = i_vld && i_rdy, where i_rdy = !o_vld || o_rdy. The path is combinational from o_rdy; there is no skid buffer.
- Counters: col_cnt has clog2(IMG_WDTH) bits; row_cnt is 3 bits and saturates at 4.
  - On acc, col_cnt increments.
  - At IMG_WDTH-1, col_cnt wraps to 0 and row_cnt increments (saturating).
- SOF: acc with i_sof=1 treats that pixel as (row 0, col 0). Counters then advance from there (col_cnt=1, row_cnt=0).
  - i_sof without acc is ignored.
  - Line buffers and window registers are not cleared; stale data is masked by the counters.
- Line buffers: four buffers LB0..LB3, each IMG_WDTH deep, indexed by col_cnt. On acc, read-before-write at the same address:
  - LB0 <= i_pix
  - LB1 <= old LB0
  - LB2 <= old LB1
  - LB3 <= old LB2
- Window shift: on acc, the window shifts one column left. The new column c=4 is {r0=old LB3, r1=old LB2, r2=old LB1, r3=old LB0, r4=i_pix}.
- Emit condition: an accepted pixel at position (row_cnt>=4, col_cnt>=4), evaluated before the increment.
- Emit timing: when the condition holds, the next cycle has o_vld=1 and o_win equal to the shifted window. Latency is 1 clk from accept to o_vld.
- Output clear: o_vld clears on o_rdy when no new emit occurs in the same cycle.
- Hold: while o_vld=1 and o_rdy=0, o_win is held stable and i_rdy=0.
- Same-cycle retire and load: if o_vld && o_rdy coincides with a new emit, the register reloads and o_vld stays 1. There is no bubble.
- Throughput: 1 pixel/clk when o_rdy=1 is held.
- Windows per frame: (IMG_WDTH-4) x (H-4) for frame height H. Rows past 4 keep emitting (row_cnt saturated).
- Line wrap: the first 4 pixels of each line produce no window, even though the window registers hold pixels from the previous line's tail.
- Reset mid-frame: everything returns to reset values at once. The next accepted pixel is (0,0) whether or not i_sof is asserted.

Optional Feature:
- Macro DIP_WIN_POS_EN.
- Defined: adds outputs o_cx (clog2(IMG_WDTH) bits) and o_cy (16 bits).
  - Both give the window-centre coordinate (col-2, row-2) and load and hold together with o_win.
  - The row counter gains a separate 16-bit unsaturated counter for o_cy; it resets on rst and on SOF.
  - Both outputs reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Basic window, IMG_WDTH=8, frame 8x6, pix=row*16+col, o_rdy=1, continuous i_vld:
  - First o_vld occurs 1 clk after accepting pixel index 36, i.e. (4,4).
  - That window has o_win(0,0)=0x00, (2,2)=0x22, (4,4)=0x44.
  - Exactly 8 windows are emitted; the last has centre 0x35.
- Backpressure: o_rdy=0 for 3 clk while o_vld=1.
  - o_win is unchanged and i_rdy=0 throughout.
  - After release, the full window sequence matches the reference model with no pixel lost or duplicated.
- Line wrap: check the windows for pixels (4,7) and (5,4).
  - The (4,7) window is followed by no o_vld for pixels (5,0)..(5,3).
  - The (5,4) window holds rows 1..5, cols 0..4 (top-left 0x10).
- SOF restart: assert i_sof on the accepted pixel at index 20 of frame 1, then send a full 8x6 frame.
  - No window before that frame's (4,4).
  - All 8 windows contain only new-frame data.
- Reset mid-operation: assert rst while o_vld=1 after 40 pixels.
  - o_vld=0 immediately (asynchronous).
  - After release, the next pixel is treated as (0,0) and the first window follows its pixel 36.
- Random i_vld/o_rdy, 50% duty, three 8x6 frames: window stream equals the golden model.
  - With DIP_WIN_POS_EN: first window (o_cx,o_cy)=(2,2), last (5,3).

Source files
------------

// File: rtl/dip_win5x5_gen.sv
// 5x5 valid-region window generator: four line buffers feed a shifting window, one-deep output register.
// Optional macro DIP_WIN_POS_EN adds window-centre coordinate outputs o_cx/o_cy.
module dip_win5x5_gen #(
    parameter  int DAT_WDTH = 8,
    parameter  int IMG_WDTH = 640,
    localparam int CW       = $clog2(IMG_WDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_vld,
    output logic                     i_rdy,
    input  logic                     i_sof,
    input  logic [DAT_WDTH-1:0]      i_pix,
    output logic                     o_vld,
    input  logic                     o_rdy,
    output logic [25*DAT_WDTH-1:0]   o_win
`ifdef DIP_WIN_POS_EN
   ,output logic [CW-1:0]            o_cx,
    output logic [15:0]              o_cy
`endif
);

    logic [CW-1:0]                col_q, col_d, col_e;
    logic [2:0]                   row_q, row_d, row_e;
    logic [24:0][DAT_WDTH-1:0]    win_q, win_d, o_win_q, o_win_d;
    logic                         o_vld_q, o_vld_d;
    logic [3:0][DAT_WDTH-1:0]     lb_mem [IMG_WDTH];
    logic [3:0][DAT_WDTH-1:0]     lb_rd, lb_wr;
    logic                         acc, emit;
`ifdef DIP_WIN_POS_EN
    logic [15:0]                  cy_q, cy_d, cy_e;
    logic [CW-1:0]                o_cx_q, o_cx_d;
    logic [15:0]                  o_cy_q, o_cy_d;
`endif

    assign i_rdy = !o_vld_q || o_rdy;
    assign acc   = i_vld && i_rdy;
    assign o_vld = o_vld_q;
    assign o_win = o_win_q;
`ifdef DIP_WIN_POS_EN
    assign o_cx  = o_cx_q;
    assign o_cy  = o_cy_q;
`endif

    always_comb begin
        // An accepted SOF pixel is position (0,0) regardless of the counters.
        col_e   = i_sof ? '0 : col_q;
        row_e   = i_sof ? '0 : row_q;
        lb_rd   = lb_mem[col_e];
        lb_wr   = {lb_rd[2], lb_rd[1], lb_rd[0], i_pix};
        emit    = acc && (row_e >= 3'd4) && (col_e >= CW'(4));
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        o_vld_d = o_vld_q;
        o_win_d = o_win_q;
`ifdef DIP_WIN_POS_EN
        cy_e    = i_sof ? '0 : cy_q;
        cy_d    = cy_q;
        o_cx_d  = o_cx_q;
        o_cy_d  = o_cy_q;
`endif
        if (acc) begin
            if (col_e == CW'(IMG_WDTH-1)) begin
                col_d = '0;
                row_d = (row_e == 3'd4) ? row_e : row_e + 3'd1;
`ifdef DIP_WIN_POS_EN
                cy_d  = cy_e + 16'd1;
`endif
            end else begin
                col_d = col_e + CW'(1);
                row_d = row_e;
`ifdef DIP_WIN_POS_EN
                cy_d  = cy_e;
`endif
            end
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 4; c++)
                    win_d[r*5+c] = win_q[r*5+c+1];
            win_d[4]  = lb_rd[3];
            win_d[9]  = lb_rd[2];
            win_d[14] = lb_rd[1];
            win_d[19] = lb_rd[0];
            win_d[24] = i_pix;
        end
        // A new emit wins over retirement so back-to-back windows need no bubble.
        if (emit) begin
            o_vld_d = 1'b1;
            o_win_d = win_d;
`ifdef DIP_WIN_POS_EN
            o_cx_d  = col_e - CW'(2);
            o_cy_d  = cy_e - 16'd2;
`endif
        end else if (o_rdy) begin
            o_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc)
            lb_mem[col_e] <= lb_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            o_vld_q <= 1'b0;
            o_win_q <= '0;
`ifdef DIP_WIN_POS_EN
            cy_q    <= '0;
            o_cx_q  <= '0;
            o_cy_q  <= '0;
`endif
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            o_vld_q <= o_vld_d;
            o_win_q <= o_win_d;
`ifdef DIP_WIN_POS_EN
            cy_q    <= cy_d;
            o_cx_q  <= o_cx_d;
            o_cy_q  <= o_cy_d;
`endif
        end
    end

endmodule

// File: tb/tb_dip_win5x5_gen.sv
// Scoreboard bench for dip_win5x5_gen with an 8-pixel-wide image.
module tb_dip_win5x5_gen;
    localparam int W  = 8;
    localparam int IW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_vld, i_rdy, i_sof, o_vld, o_rdy;
    logic [W-1:0] i_pix;
    logic [199:0] o_win;
`ifdef DIP_WIN_POS_EN
    logic [2:0]   o_cx;
    logic [15:0]  o_cy;
`endif

    dip_win5x5_gen #(.DAT_WDTH(W), .IMG_WDTH(IW)) dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .i_sof(i_sof),
        .i_pix(i_pix), .o_vld(o_vld), .o_rdy(o_rdy), .o_win(o_win)
`ifdef DIP_WIN_POS_EN
       ,.o_cx(o_cx), .o_cy(o_cy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [199:0] win; int cx; int cy; } exp_t;
    exp_t         sbq[$];
    exp_t         mon_e;
    int           tests = 0, fails = 0, win_cnt = 0;
    logic [199:0] last_win = '0;
    int           mrow = 0, mcol = 0;
    logic [W-1:0] img [64][IW];

    // Reference: store the frame as a 2-D image and cut windows out of it.
    function automatic void model_accept(input logic [W-1:0] pix, input logic sof);
        exp_t e;
        if (sof) begin mrow = 0; mcol = 0; end
        img[mrow % 64][mcol] = pix;
        if (mrow >= 4 && mcol >= 4) begin
            e.win = '0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    e.win[(r*5+c)*8 +: 8] = img[(mrow-4+r) % 64][mcol-4+c];
            e.cx = mcol - 2;
            e.cy = mrow - 2;
            sbq.push_back(e);
        end
        mcol++;
        if (mcol == IW) begin mcol = 0; mrow++; end
    endfunction

    always @(negedge clk) begin
        if (!rst && o_vld && o_rdy) begin
            tests++;
            win_cnt++;
            last_win = o_win;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_window got %h expected none", o_win);
            end else begin
                mon_e = sbq.pop_front();
                if (o_win !== mon_e.win) begin
                    fails++;
                    $display("FAIL window got %h expected %h", o_win, mon_e.win);
                end
`ifdef DIP_WIN_POS_EN
                if (o_cx !== 3'(mon_e.cx) || o_cy !== 16'(mon_e.cy)) begin
                    fails++;
                    $display("FAIL window_pos got (%0d,%0d) expected (%0d,%0d)", o_cx, o_cy, mon_e.cx, mon_e.cy);
                end
`endif
            end
        end
    end

    task automatic send(input logic [W-1:0] pix, input logic sof);
        i_vld = 1'b1; i_pix = pix; i_sof = sof;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (i_rdy) begin
                model_accept(pix, sof);
                @(posedge clk); #1;
                i_vld = 1'b0; i_sof = 1'b0;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL send_timeout got i_rdy=0 expected 1 within 200 clk");
        i_vld = 1'b0; i_sof = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && sbq.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_vld = 1'b0; i_sof = 1'b0; i_pix = '0; o_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (o_vld !== 1'b0 || o_win !== '0 || i_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset got vld=%b win=%h rdy=%b expected 0 0 1", o_vld, o_win, i_rdy);
        end
    endtask

    task automatic test_basic();
        logic exp_v;
        win_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            send(8'((k/8)*16 + k%8), k == 0);
            exp_v = (k/8 >= 4) && (k%8 >= 4);
            tests++;
            if (o_vld !== exp_v) begin
                fails++;
                $display("FAIL basic_vld idx %0d got %b expected %b", k, o_vld, exp_v);
            end
            if (k == 36) begin
                tests++;
                if (o_win[7:0] !== 8'h00 || o_win[12*8 +: 8] !== 8'h22 || o_win[24*8 +: 8] !== 8'h44) begin
                    fails++;
                    $display("FAIL basic_first got %h/%h/%h expected 00/22/44",
                             o_win[7:0], o_win[12*8 +: 8], o_win[24*8 +: 8]);
                end
            end
        end
        drain();
        tests++;
        if (win_cnt != 8 || last_win[12*8 +: 8] !== 8'h35) begin
            fails++;
            $display("FAIL basic_count got %0d windows centre %h expected 8 centre 35", win_cnt, last_win[12*8 +: 8]);
        end
    endtask

    task automatic test_backpressure();
        logic [199:0] held;
        for (int k = 0; k < 37; k++) send(8'($urandom), k == 0);
        o_rdy = 1'b0;
        held  = o_win;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            tests++;
            if (o_vld !== 1'b1 || o_win !== held || i_rdy !== 1'b0) begin
                fails++;
                $display("FAIL backpressure cyc %0d got vld=%b rdy=%b win=%h expected 1 0 %h", n, o_vld, i_rdy, o_win, held);
            end
        end
        @(posedge clk); #1 o_rdy = 1'b1;
        for (int k = 37; k < 48; k++) send(8'($urandom), 1'b0);
        drain();
    endtask

    task automatic test_line_wrap();
        for (int k = 0; k < 48; k++) begin
            send(8'((k/8)*16 + k%8), k == 0);
            if (k == 39) begin
                tests++;
                if (o_vld !== 1'b1 || o_win[12*8 +: 8] !== 8'h25) begin
                    fails++;
                    $display("FAIL wrap_47 got vld=%b centre %h expected 1 25", o_vld, o_win[12*8 +: 8]);
                end
            end
            if (k >= 40 && k <= 43) begin
                tests++;
                if (o_vld !== 1'b0) begin
                    fails++;
                    $display("FAIL wrap_gap idx %0d got vld=%b expected 0", k, o_vld);
                end
            end
            if (k == 44) begin
                tests++;
                if (o_vld !== 1'b1 || o_win[7:0] !== 8'h10 || o_win[12*8 +: 8] !== 8'h32) begin
                    fails++;
                    $display("FAIL wrap_54 got tl %h centre %h expected 10 32", o_win[7:0], o_win[12*8 +: 8]);
                end
            end
        end
        drain();
    endtask

    task automatic test_sof_restart();
        win_cnt = 0;
        for (int k = 0; k < 20; k++) send(8'($urandom), k == 0);
        drain();
        for (int k = 0; k < 48; k++) send(8'($urandom), k == 0);
        drain();
        tests++;
        if (win_cnt != 8) begin
            fails++;
            $display("FAIL sof_count got %0d expected 8", win_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 40; k++) send(8'($urandom), k == 0);
        tests++;
        if (o_vld !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre got vld=%b expected 1", o_vld);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (o_vld !== 1'b0 || o_win !== '0 || i_rdy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_async got vld=%b win=%h expected 0 0", o_vld, o_win);
        end
        sbq.delete();
        mrow = 0; mcol = 0;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 48; k++) begin
            send(8'($urandom), 1'b0);
            if (k == 35 || k == 36) begin
                tests++;
                if (o_vld !== (k == 36)) begin
                    fails++;
                    $display("FAIL rstmid_first idx %0d got vld=%b expected %b", k, o_vld, k == 36);
                end
            end
        end
        drain();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        win_cnt = 0;
        fork
            begin
                for (int f = 0; f < 3; f++)
                    for (int k = 0; k < 48; k++) begin
                        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
                        send(8'($urandom), k == 0);
                    end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    o_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        o_rdy = 1'b1;
        drain();
        tests++;
        if (win_cnt != 24) begin
            fails++;
            $display("FAIL random_count got %0d expected 24", win_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_line_wrap();
        test_sof_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
